// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub, iterative shift-add multiply
// and restoring divide, with a two-state IDLE/RUN controller.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               cout,
  output logic               zero,
  output logic               dz
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               cin_q, cin_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               cout_q, cout_d;
  logic               zero_q, zero_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;

  logic               fin;
  logic [2*WIDTH-1:0] res_n;
  logic               cout_n;
  logic               dz_n;
  logic               last;

  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] dif_w;
  logic [WIDTH:0] mac_w;
  logic [WIDTH:0] sh_w;
  logic [WIDTH:0] trial_w;

  assign sum_w = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
  assign dif_w = {1'b0, a_q} - {1'b0, b_q};
  // Multiply: acc = {partial high, remaining multiplier bits}
  assign mac_w = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  // Divide: acc = {remainder, dividend/quotient}
  assign sh_w    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign trial_w = sh_w - {1'b0, b_q};
  assign last    = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    fin      = 1'b0;
    res_n    = '0;
    cout_n   = 1'b0;
    dz_n     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          op_d    = op;
          a_d     = a;
          b_d     = b;
          cin_d   = cin;
          cnt_d   = '0;
          acc_d   = (op == OP_MUL) ? {{WIDTH{1'b0}}, b}
                                   : {{WIDTH{1'b0}}, a};
        end
      end
      RUN: begin
        unique case (op_q)
          OP_ADD: begin
            fin    = 1'b1;
            res_n  = {{(WIDTH-1){1'b0}}, sum_w};
            cout_n = sum_w[WIDTH];
          end
          OP_SUB: begin
            fin    = 1'b1;
            res_n  = {{WIDTH{1'b0}}, dif_w[WIDTH-1:0]};
            cout_n = dif_w[WIDTH];
          end
          OP_MUL: begin
            acc_d = {mac_w, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            fin   = last;
            res_n = acc_d;
          end
          OP_DIV: begin
            if (b_q == '0) begin
              fin   = 1'b1;
              res_n = {a_q, {WIDTH{1'b1}}};
              dz_n  = 1'b1;
            end else begin
              if (!trial_w[WIDTH])
                acc_d = {trial_w[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
              else
                acc_d = {sh_w[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
              cnt_d = cnt_q + 1'b1;
              fin   = last;
              res_n = acc_d;
            end
          end
        endcase
        if (fin) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          result_d = res_n;
          cout_d   = cout_n;
          dz_d     = dz_n;
          zero_d   = (res_n == '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;
  assign dz     = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=16) with an expected-result queue
// filled at issue time and drained at each done pulse.
module tb_seq_alu;

  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           cin;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           cout;
  logic           zero;
  logic           dz;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        cout;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t dummy;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   seen;

  seq_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .zero   (zero),
    .dz     (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive a request and push the reference result
  task automatic issue(input string tag, input logic [1:0] o,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c);
    exp_t e;
    logic [W-1:0] d;
    e.tag  = tag;
    e.cout = 1'b0;
    e.dz   = 1'b0;
    e.lat  = W;
    case (o)
      2'b00: begin
        e.res  = 32'(x) + 32'(y) + 32'(c);
        e.cout = e.res[W];
        e.lat  = 1;
      end
      2'b01: begin
        d      = x - y;
        e.res  = {16'h0, d};
        e.cout = (x < y);
        e.lat  = 1;
      end
      2'b10: e.res = 32'(x) * 32'(y);
      default: begin
        if (y == 0) begin
          e.res = {x, 16'hFFFF};
          e.dz  = 1'b1;
          e.lat = 1;
        end else begin
          e.res = {x % y, x / y};
        end
      end
    endcase
    sb.push_back(e);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    cin   = c;
  endtask

  task automatic accept(input string tag);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, " accept busy"}, busy, 1);
    chk({tag, " accept done"}, done, 0);
  endtask

  task automatic wait_done(input int n0);
    int   n;
    exp_t e;
    n = n0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 64);
    if (sb.size() == 0) begin
      chk("scoreboard empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, " done seen"}, done, 1);
      if (done) begin
        chk({e.tag, " latency"}, n, e.lat);
        chk({e.tag, " result"}, result, e.res);
        chk({e.tag, " cout"}, cout, e.cout);
        chk({e.tag, " zero"}, zero, (e.res == 0));
        chk({e.tag, " dz"}, dz, e.dz);
        chk({e.tag, " busy low"}, busy, 0);
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c);
    @(negedge clk);
    issue(tag, o, x, y, c);
    accept(tag);
    wait_done(0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 0);
    chk("reset flags", {cout, zero, dz}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add1", 2'b00, 16'd340, 16'd45, 1'b1);
    run_op("add2", 2'b00, 16'd65535, 16'd1, 1'b0);
    run_op("sub1", 2'b01, 16'd678, 16'd32, 1'b0);
    run_op("sub2", 2'b01, 16'd30, 16'd450, 1'b0);

    // Multiply with a start pulse and operand change while busy
    @(negedge clk);
    issue("mul1", 2'b10, 16'd30, 16'd450, 1'b0);
    accept("mul1");
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    a     = 16'd7;
    b     = 16'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(4);
    @(posedge clk);
    #1;
    chk("mul1 no queued start", busy, 0);
    chk("mul1 single done", done, 0);
    chk("mul1 result hold", result, 32'd13500);

    // Back-to-back: next start issued in the done cycle
    run_op("mul2", 2'b10, 16'hFFFF, 16'hFFFF, 1'b0);
    issue("b2b add", 2'b00, 16'd5, 16'd6, 1'b0);
    accept("b2b add");
    wait_done(0);

    run_op("div1", 2'b11, 16'd234, 16'd3, 1'b0);
    run_op("div2", 2'b11, 16'd1, 16'd5, 1'b0);
    run_op("div0", 2'b11, 16'd7, 16'd0, 1'b0);
    run_op("sub after dz", 2'b01, 16'd9, 16'd9, 1'b0);

    // Reset in the middle of a divide
    @(negedge clk);
    issue("div abort", 2'b11, 16'd1000, 16'd7, 1'b0);
    accept("div abort");
    dummy = sb.pop_back();
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort result", result, 0);
    chk("abort flags", {cout, zero, dz}, 0);
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("abort no done", seen, 0);

    run_op("add zero", 2'b00, 16'd0, 16'd0, 1'b0);
    chk("queue drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
